// File: rtl/i2c_target_reg16.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_target_reg16
//  Purpose  : I2C target engine with 7-bit chip address, 8-bit register
//             address and 16-bit data words. Writes are handed to an external
//             register file by a one-cycle strobe; reads fetch a word from it
//             and shift it out MSB first. Register address auto-increments.
//  Ports    : clk, reset          - system clock, synchronous active-high reset
//             enable              - 1 = take part in bus traffic
//             chip_id             - own 7-bit target address (0 = never match)
//             sda_in, scl_in      - bus levels
//             sda_out/sda_oen     - open-drain SDA driver (oen=0 pulls low)
//             scl_out/scl_oen     - SCL driver, permanently released
//             reg_addr            - current register address
//             write_en, data_out  - write strobe and write word
//             read_req, data_in   - read strobe; data_in sampled one clk later
//             busy, done          - addressed flag, end-of-transaction pulse
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_target_reg16 #(
   parameter int FILTER_LEN = 3,
   parameter int DATA_BYTES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [6:0]              chip_id,
   input  logic                    sda_in,
   input  logic                    scl_in,
   output logic                    sda_out,
   output logic                    sda_oen,
   output logic                    scl_out,
   output logic                    scl_oen,
   output logic [7:0]              reg_addr,
   output logic                    write_en,
   output logic [8*DATA_BYTES-1:0] data_out,
   output logic                    read_req,
   input  logic [8*DATA_BYTES-1:0] data_in,
   output logic                    busy,
   output logic                    done
);

   localparam int WORD_W = 8 * DATA_BYTES;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
   } state_t;

   // ---------------------------------------------------------------
   // Input conditioning: bit 0 = SCL, bit 1 = SDA
   // ---------------------------------------------------------------
   logic [1:0] raw_w;
   logic [1:0] filt_w;
   logic [1:0] filt_prev_q;

   assign raw_w = {sda_in, scl_in};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cond
         logic [1:0]            sync_q;
         logic [FILTER_LEN-1:0] hist_q;
         logic                  lvl_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               sync_q <= 2'b11;
               hist_q <= '1;
               lvl_q  <= 1'b1;
            end else begin
               sync_q <= {sync_q[0], raw_w[gi]};
               hist_q <= FILTER_LEN'({hist_q, sync_q[1]});
               // Level only moves once the whole history window agrees
               if (&hist_q)
                  lvl_q <= 1'b1;
               else if (~|hist_q)
                  lvl_q <= 1'b0;
            end
         end
         assign filt_w[gi] = lvl_q;
      end
   endgenerate

   logic scl_rise_w, scl_fall_w, start_w, stop_w;
   assign scl_rise_w =  filt_w[0] & ~filt_prev_q[0];
   assign scl_fall_w = ~filt_w[0] &  filt_prev_q[0];
   assign start_w    = ~filt_w[1] &  filt_prev_q[1] & filt_w[0] & filt_prev_q[0];
   assign stop_w     =  filt_w[1] & ~filt_prev_q[1] & filt_w[0] & filt_prev_q[0];

   // ---------------------------------------------------------------
   // Protocol FSM
   // ---------------------------------------------------------------
   state_t              state_q, state_d;
   logic [3:0]          bitcnt_q, bitcnt_d;
   logic [WORD_W-1:0]   rx_q, rx_d;
   logic [WORD_W-1:0]   tx_q, tx_d;
   logic                byte_q, byte_d;     // 0 = MSB byte, 1 = LSB byte
   logic                mack_q, mack_d;     // master ACK seen on last read byte
   logic                oen_q, oen_d;
   logic [7:0]          reg_addr_q, reg_addr_d;
   logic [WORD_W-1:0]   data_out_q, data_out_d;
   logic                write_en_q, write_en_d;
   logic                read_req_q, read_req_d;
   logic                load_q, load_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                addr_hit_w;

   assign addr_hit_w = (rx_q[7:1] == chip_id) && (chip_id != 7'd0);

   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      byte_d     = byte_q;
      mack_d     = mack_q;
      oen_d      = oen_q;
      reg_addr_d = reg_addr_q;
      data_out_d = data_out_q;
      busy_d     = busy_q;
      write_en_d = 1'b0;
      read_req_d = 1'b0;
      done_d     = 1'b0;
      // Read data arrives one clk after the request
      load_d     = read_req_q;

      if (write_en_q)
         reg_addr_d = reg_addr_q + 8'd1;
      if (load_q)
         tx_d = data_in;

      if (!enable) begin
         state_d    = S_IDLE;
         oen_d      = 1'b1;
         busy_d     = 1'b0;
         bitcnt_d   = 4'd0;
         data_out_d = '0;
         load_d     = 1'b0;
      end else if (stop_w) begin
         state_d = S_IDLE;
         oen_d   = 1'b1;
         done_d  = busy_q;
         busy_d  = 1'b0;
      end else if (start_w) begin
         state_d  = S_ADDR;
         oen_d    = 1'b1;
         bitcnt_d = 4'd0;
         byte_d   = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_REG, S_WDATA: begin
               if (scl_rise_w) begin
                  rx_d     = {rx_q[WORD_W-2:0], filt_w[1]};
                  bitcnt_d = bitcnt_q + 4'd1;
               end
               // ACK is decided on the falling edge after the 8th bit
               if (scl_fall_w && bitcnt_q == 4'd8) begin
                  oen_d = 1'b0;
                  case (state_q)
                     S_ADDR: begin
                        if (addr_hit_w) begin
                           state_d    = S_ADDR_ACK;
                           busy_d     = 1'b1;
                           read_req_d = rx_q[0];
                        end else begin
                           state_d = S_WAIT_STOP;
                           oen_d   = 1'b1;
                        end
                     end
                     S_REG: begin
                        state_d    = S_REG_ACK;
                        reg_addr_d = rx_q[7:0];
                     end
                     default: state_d = S_WDATA_ACK;
                  endcase
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall_w) begin
                  bitcnt_d = 4'd0;
                  byte_d   = 1'b0;
                  if (rx_q[0]) begin
                     state_d = S_RDATA;
                     oen_d   = tx_q[WORD_W-1];
                     tx_d    = {tx_q[WORD_W-2:0], 1'b0};
                  end else begin
                     state_d = S_REG;
                     oen_d   = 1'b1;
                  end
               end
            end
            S_REG_ACK: begin
               if (scl_fall_w) begin
                  state_d  = S_WDATA;
                  oen_d    = 1'b1;
                  bitcnt_d = 4'd0;
                  byte_d   = 1'b0;
               end
            end
            S_WDATA_ACK: begin
               if (scl_fall_w) begin
                  state_d  = S_WDATA;
                  oen_d    = 1'b1;
                  bitcnt_d = 4'd0;
                  byte_d   = ~byte_q;
                  if (byte_q) begin
                     write_en_d = 1'b1;
                     data_out_d = rx_q;
                  end
               end
            end
            S_RDATA: begin
               if (scl_rise_w)
                  bitcnt_d = bitcnt_q + 4'd1;
               if (scl_fall_w) begin
                  if (bitcnt_q == 4'd8) begin
                     state_d  = S_RDATA_ACK;
                     oen_d    = 1'b1;
                     bitcnt_d = 4'd0;
                  end else begin
                     oen_d = tx_q[WORD_W-1];
                     tx_d  = {tx_q[WORD_W-2:0], 1'b0};
                  end
               end
            end
            S_RDATA_ACK: begin
               // Fetch the next word already at the ACK rise so it is
               // loaded before the first bit has to be driven.
               if (scl_rise_w) begin
                  mack_d = ~filt_w[1];
                  if (!filt_w[1] && byte_q) begin
                     reg_addr_d = reg_addr_q + 8'd1;
                     read_req_d = 1'b1;
                  end
               end
               if (scl_fall_w) begin
                  if (!mack_q) begin
                     state_d = S_WAIT_STOP;
                     oen_d   = 1'b1;
                  end else begin
                     state_d = S_RDATA;
                     byte_d  = ~byte_q;
                     oen_d   = tx_q[WORD_W-1];
                     tx_d    = {tx_q[WORD_W-2:0], 1'b0};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         filt_prev_q <= 2'b11;
         state_q     <= S_IDLE;
         bitcnt_q    <= 4'd0;
         rx_q        <= '0;
         tx_q        <= '0;
         byte_q      <= 1'b0;
         mack_q      <= 1'b0;
         oen_q       <= 1'b1;
         reg_addr_q  <= 8'd0;
         data_out_q  <= '0;
         write_en_q  <= 1'b0;
         read_req_q  <= 1'b0;
         load_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         filt_prev_q <= filt_w;
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         byte_q      <= byte_d;
         mack_q      <= mack_d;
         oen_q       <= oen_d;
         reg_addr_q  <= reg_addr_d;
         data_out_q  <= data_out_d;
         write_en_q  <= write_en_d;
         read_req_q  <= read_req_d;
         load_q      <= load_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign sda_out  = 1'b0;
   assign sda_oen  = oen_q;
   assign scl_out  = 1'b0;
   assign scl_oen  = 1'b1;
   assign reg_addr = reg_addr_q;
   assign write_en = write_en_q;
   assign data_out = data_out_q;
   assign read_req = read_req_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_reg16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_target_reg16
//  Purpose  : Bus-level bench for i2c_target_reg16. A bit-banged master runs
//             transactions; a transaction-level model predicts the register
//             file contents and the strobe/done event stream, which a monitor
//             compares against what the target presents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_reg16;

   localparam int         Q   = 8;        // quarter SCL period in clk cycles
   localparam logic [6:0] CID = 7'h0F;
   localparam logic [1:0] K_WR = 2'd1, K_RD = 2'd2, K_DONE = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [7:0]  addr;
      logic [15:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic        m_sda = 1'b1;
   logic        m_scl = 1'b1;
   logic        sda_bus;
   logic        sda_out, sda_oen, scl_out, scl_oen;
   logic [7:0]  reg_addr;
   logic        write_en, read_req, busy, done;
   logic [15:0] data_out;
   bit   [15:0] data_in;

   always #5 clk = ~clk;

   assign sda_bus = m_sda & (sda_oen | sda_out);

   i2c_target_reg16 #(.FILTER_LEN(3), .DATA_BYTES(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .chip_id(CID),
      .sda_in(sda_bus), .scl_in(m_scl & (scl_oen | scl_out)),
      .sda_out(sda_out), .sda_oen(sda_oen), .scl_out(scl_out), .scl_oen(scl_oen),
      .reg_addr(reg_addr), .write_en(write_en), .data_out(data_out),
      .read_req(read_req), .data_in(data_in), .busy(busy), .done(done)
   );

   function automatic logic [15:0] init_val(input logic [7:0] a);
      return {a ^ 8'hA5, ~a};
   endfunction

   // External register file the target talks to
   bit [15:0] regfile [256];
   bit        written [256];
   always @(posedge clk) begin
      if (write_en) begin
         regfile[reg_addr] <= data_out;
         written[reg_addr] <= 1'b1;
      end
      if (read_req)
         data_in <= written[reg_addr] ? regfile[reg_addr] : init_val(reg_addr);
   end

   // Reference model and scoreboard
   logic [15:0] mem [256];
   logic [7:0]  ptr;
   logic [15:0] wq [$];
   ev_t         exp_q [$];
   int          checks = 0, errors = 0;
   int          low_cnt = 0, busy_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic ev_t mk(input logic [1:0] k, input logic [7:0] a, input logic [15:0] d);
      ev_t e;
      e.kind = k; e.addr = a; e.data = d;
      return e;
   endfunction

   // Monitor: pops one expected event per strobe the target presents
   initial begin
      ev_t obs, e;
      forever begin
         @(negedge clk);
         if (!sda_oen) low_cnt++;
         if (busy)     busy_cnt++;
         if (write_en || read_req || done) begin
            chk("strobe_exclusive", 32'({write_en, read_req, done} inside {3'b100, 3'b010, 3'b001}), 32'd1);
            if (write_en)      obs = mk(K_WR, reg_addr, data_out);
            else if (read_req) obs = mk(K_RD, reg_addr, 16'h0000);
            else               obs = mk(K_DONE, 8'h00, 16'h0000);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event actual=%h expected=none", obs);
            end else begin
               e = exp_q.pop_front();
               chk("event", 32'(obs), 32'(e));
            end
         end
      end
   end

   // ---------------- bit-banged master ----------------
   task automatic qw();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic mbit(input logic b, output logic r);
      qw(); m_sda = b;
      qw(); m_scl = 1'b1;
      qw(); r = sda_bus;
      qw(); m_scl = 1'b0;
   endtask

   task automatic m_start();
      m_sda = 1'b1; qw();
      m_scl = 1'b1; qw();
      m_sda = 1'b0; qw();
      m_scl = 1'b0;
   endtask

   task automatic m_stop();
      qw(); m_sda = 1'b0;
      qw(); m_scl = 1'b1;
      qw(); m_sda = 1'b1;
      qw(); qw();
   endtask

   task automatic m_wbyte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) mbit(b[i], r);
      mbit(1'b1, r);
      ack = ~r;
   endtask

   task automatic m_rbyte(output logic [7:0] b, input logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         mbit(1'b1, r);
         b[i] = r;
      end
      mbit(~ack, r);
   endtask

   // ---------------- transactions ----------------
   task automatic tr_write(input logic [7:0] ra, input int nw);
      logic ack;
      logic [15:0] d;
      m_start();
      m_wbyte({CID, 1'b0}, ack); chk("wr_addr_ack", 32'(ack), 32'd1);
      m_wbyte(ra, ack);          chk("wr_reg_ack", 32'(ack), 32'd1);
      ptr = ra;
      for (int w = 0; w < nw; w++) begin
         d = (wq.size() > 0) ? wq.pop_front() : 16'($urandom);
         exp_q.push_back(mk(K_WR, ptr, d));
         mem[ptr] = d;
         ptr = ptr + 8'd1;
         m_wbyte(d[15:8], ack); chk("wr_msb_ack", 32'(ack), 32'd1);
         m_wbyte(d[7:0], ack);  chk("wr_lsb_ack", 32'(ack), 32'd1);
      end
      exp_q.push_back(mk(K_DONE, 8'h00, 16'h0000));
      m_stop();
      chk("busy_after_write", 32'(busy), 32'd0);
   endtask

   task automatic tr_read(input bit setreg, input logic [7:0] ra, input int nw);
      logic ack;
      logic [7:0] hi, lo;
      int snap;
      if (setreg) begin
         m_start();
         m_wbyte({CID, 1'b0}, ack); chk("rd_waddr_ack", 32'(ack), 32'd1);
         m_wbyte(ra, ack);          chk("rd_reg_ack", 32'(ack), 32'd1);
         ptr = ra;
      end
      m_start();
      exp_q.push_back(mk(K_RD, ptr, 16'h0000));
      m_wbyte({CID, 1'b1}, ack); chk("rd_addr_ack", 32'(ack), 32'd1);
      for (int w = 0; w < nw; w++) begin
         m_rbyte(hi, 1'b1);
         if (w < nw - 1) exp_q.push_back(mk(K_RD, ptr + 8'd1, 16'h0000));
         m_rbyte(lo, w < nw - 1);
         chk("rd_data", 32'({hi, lo}), 32'(mem[ptr]));
         if (w < nw - 1) ptr = ptr + 8'd1;
      end
      snap = low_cnt;
      exp_q.push_back(mk(K_DONE, 8'h00, 16'h0000));
      m_stop();
      chk("sda_released_after_nack", 32'(low_cnt), 32'(snap));
      chk("busy_after_read", 32'(busy), 32'd0);
   endtask

   task automatic tr_bad(input logic [6:0] a);
      logic ack;
      int snap_l, snap_b;
      snap_l = low_cnt;
      snap_b = busy_cnt;
      m_start();
      m_wbyte({a, 1'b0}, ack); chk("bad_addr_nack", 32'(ack), 32'd0);
      m_wbyte(8'h55, ack);     chk("bad_byte_nack", 32'(ack), 32'd0);
      m_stop();
      chk("bad_sda_never_low", 32'(low_cnt), 32'(snap_l));
      chk("bad_busy_never_high", 32'(busy_cnt), 32'(snap_b));
   endtask

   task automatic tr_abort(input logic [7:0] ra);
      logic ack;
      logic [15:0] d;
      d = 16'($urandom);
      m_start();
      m_wbyte({CID, 1'b0}, ack); chk("ab_addr_ack", 32'(ack), 32'd1);
      m_wbyte(ra, ack);          chk("ab_reg_ack", 32'(ack), 32'd1);
      ptr = ra;
      m_wbyte(d[15:8], ack);     chk("ab_msb_ack", 32'(ack), 32'd1);
      exp_q.push_back(mk(K_DONE, 8'h00, 16'h0000));
      m_stop();
      chk("busy_after_abort", 32'(busy), 32'd0);
   endtask

   task automatic tr_reset_in_read();
      logic ack;
      bit seen;
      wq.push_back(16'h1234);            // MSB 0: target drives SDA low first
      tr_write(8'h20, 1);
      m_start();
      m_wbyte({CID, 1'b0}, ack);
      m_wbyte(8'h20, ack);
      ptr = 8'h20;
      m_start();
      exp_q.push_back(mk(K_RD, ptr, 16'h0000));
      m_wbyte({CID, 1'b1}, ack); chk("rst_addr_ack", 32'(ack), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (!sda_oen) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rst_target_driving", 32'(seen), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_sda_released", 32'(sda_oen), 32'd1);
      chk("rst_outputs", {reg_addr, write_en, read_req, busy, done, data_out, 4'h0},
          {8'h00, 4'h0, 16'h0000, 4'h0});
      m_scl = 1'b1;
      m_sda = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      ptr = 8'h00;
      repeat (5) @(posedge clk);
      #1;
   endtask

   // Watchdog
   initial begin
      #3ms;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] a;
      for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
      ptr = 8'h00;
      repeat (6) @(posedge clk);
      #1;
      chk("reset_values", {sda_oen, reg_addr, write_en, read_req, busy, done, data_out, 3'b0},
          {1'b1, 8'h00, 4'h0, 16'h0000, 3'b0});
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      wq.push_back(16'hA1A1);
      tr_write(8'h0A, 1);
      wq.push_back(16'h1234); wq.push_back(16'h5678);
      tr_write(8'hFF, 2);
      wq.push_back(16'hC3C3); wq.push_back(16'hD4D4);
      tr_write(8'h10, 2);
      tr_read(1'b1, 8'h10, 2);
      tr_bad(7'h0E);
      tr_bad(7'h00);
      tr_abort(8'h05);
      wq.push_back(16'hB2B2);
      tr_write(8'h01, 1);
      tr_reset_in_read();
      tr_write(8'h33, 1);

      for (int t = 0; t < 10; t++) begin
         case ($urandom_range(0, 4))
            0: tr_write(8'($urandom), $urandom_range(1, 3));
            1: tr_read(1'b1, 8'($urandom), $urandom_range(1, 3));
            2: tr_read(1'b0, 8'h00, $urandom_range(1, 2));
            3: begin
               a = 7'($urandom);
               if (a == CID) a = 7'h00;
               tr_bad(a);
            end
            default: tr_abort(8'($urandom));
         endcase
      end

      repeat (20) @(posedge clk);
      #1;
      chk("events_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
